// File: rtl/led_pattern_pkg.sv
// ---------------------------------------------------------------------------
// led_pattern_pkg : shared types and constants for the LED sequencer
// Rev 1.0
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

package led_pattern_pkg;

  localparam int LED_WIDTH = 4;
  localparam logic [LED_WIDTH-1:0] LED_INIT = 4'b0001;

  typedef enum logic {
    MODE_A = 1'b0,
    MODE_B = 1'b1
  } mode_e;

  typedef enum logic {
    SPD_1S = 1'b0,
    SPD_3S = 1'b1
  } speed_e;

  typedef enum logic {
    DIR_UP   = 1'b0,
    DIR_DOWN = 1'b1
  } dir_e;

  function automatic logic f_is_onehot(input logic [LED_WIDTH-1:0] v);
    return (v != '0) && ((v & (v - LED_WIDTH'(1))) == '0);
  endfunction

endpackage

`default_nettype wire

// File: rtl/btn_pulse.sv
// ---------------------------------------------------------------------------
// btn_pulse : 2-FF synchronizer, level debounce and one-cycle press pulse
// Rev 1.0
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module btn_pulse #(
  parameter int DEBOUNCE_CYCLES = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic i_btn,
  output logic o_pulse
);

  localparam int C_CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

  logic [1:0]         r_sync;
  logic [C_CNT_W-1:0] r_cnt;
  logic               r_stable;
  logic               r_stable_q;

  // Accepted level only flips after DEBOUNCE_CYCLES consecutive differing samples.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync     <= '0;
      r_cnt      <= '0;
      r_stable   <= 1'b0;
      r_stable_q <= 1'b0;
    end else begin
      r_sync     <= {r_sync[0], i_btn};
      r_stable_q <= r_stable;
      if (r_sync[1] == r_stable) begin
        r_cnt <= '0;
      end else if (r_cnt == C_CNT_W'(DEBOUNCE_CYCLES - 1)) begin
        r_stable <= r_sync[1];
        r_cnt    <= '0;
      end else begin
        r_cnt <= r_cnt + C_CNT_W'(1);
      end
    end
  end

  assign o_pulse = r_stable & ~r_stable_q;

endmodule

`default_nettype wire

// File: rtl/led_pattern_top.sv
// ---------------------------------------------------------------------------
// led_pattern_top : 4-LED ping-pong / rotate sequencer with mode and speed buttons
// Rev 1.0
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module led_pattern_top
  import led_pattern_pkg::*;
#(
  parameter int CYCLES_PER_SEC  = 125_000_000,
  parameter int SLOW_FACTOR     = 3,
  parameter int DEBOUNCE_CYCLES = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 btn0,
  input  logic                 btn1,
  output logic [LED_WIDTH-1:0] leds
);

  localparam int C_LIMIT_FAST = CYCLES_PER_SEC;
  localparam int C_LIMIT_SLOW = CYCLES_PER_SEC * SLOW_FACTOR;
  localparam int C_CNT_W      = $clog2(C_LIMIT_SLOW);

  logic                 w_pls0;
  logic                 w_pls1;
  logic                 w_tick;
  logic [C_CNT_W-1:0]   w_limit_m1;

  logic [C_CNT_W-1:0]   r_cnt,  w_cnt_nxt;
  logic [LED_WIDTH-1:0] r_leds, w_leds_nxt;
  mode_e                r_mode, w_mode_nxt;
  speed_e               r_speed, w_speed_nxt;
  dir_e                 r_dir,  w_dir_nxt;

  btn_pulse #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_btn0 (
    .clk     (clk),
    .rst     (rst),
    .i_btn   (btn0),
    .o_pulse (w_pls0)
  );

  btn_pulse #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_btn1 (
    .clk     (clk),
    .rst     (rst),
    .i_btn   (btn1),
    .o_pulse (w_pls1)
  );

  assign w_limit_m1 = (r_speed == SPD_3S) ? C_CNT_W'(C_LIMIT_SLOW - 1)
                                          : C_CNT_W'(C_LIMIT_FAST - 1);
  // >= rather than == so a counter left above a freshly shortened limit still wraps.
  assign w_tick     = (r_cnt >= w_limit_m1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt   <= '0;
      r_leds  <= LED_INIT;
      r_mode  <= MODE_A;
      r_speed <= SPD_1S;
      r_dir   <= DIR_UP;
    end else begin
      r_cnt   <= w_cnt_nxt;
      r_leds  <= w_leds_nxt;
      r_mode  <= w_mode_nxt;
      r_speed <= w_speed_nxt;
      r_dir   <= w_dir_nxt;
    end
  end

  always_comb begin
    w_cnt_nxt   = w_tick ? '0 : r_cnt + C_CNT_W'(1);
    w_leds_nxt  = r_leds;
    w_mode_nxt  = r_mode;
    w_speed_nxt = r_speed;
    w_dir_nxt   = r_dir;

    if (w_pls1) begin
      w_speed_nxt = (r_speed == SPD_1S) ? SPD_3S : SPD_1S;
      w_cnt_nxt   = '0;
    end

    if (w_pls0) begin
      w_mode_nxt = (r_mode == MODE_A) ? MODE_B : MODE_A;
      w_leds_nxt = LED_INIT;
      w_dir_nxt  = DIR_UP;
      w_cnt_nxt  = '0;
    end

    // Button presses take priority over a coincident step.
    if (!w_pls0 && !w_pls1 && w_tick) begin
      if (!f_is_onehot(r_leds)) begin
        w_leds_nxt = LED_INIT;
        w_dir_nxt  = DIR_UP;
      end else if (r_mode == MODE_B) begin
        w_leds_nxt = {r_leds[LED_WIDTH-2:0], r_leds[LED_WIDTH-1]};
      end else if (r_dir == DIR_UP) begin
        if (r_leds[LED_WIDTH-1]) begin
          w_leds_nxt = r_leds >> 1;
          w_dir_nxt  = DIR_DOWN;
        end else begin
          w_leds_nxt = r_leds << 1;
          if (r_leds[LED_WIDTH-2]) w_dir_nxt = DIR_DOWN;
        end
      end else begin
        if (r_leds[0]) begin
          w_leds_nxt = r_leds << 1;
          w_dir_nxt  = DIR_UP;
        end else begin
          w_leds_nxt = r_leds >> 1;
          if (r_leds[1]) w_dir_nxt = DIR_UP;
        end
      end
    end
  end

  assign leds = r_leds;

endmodule

`default_nettype wire

// File: tb/tb_led_pattern_top.sv
// ---------------------------------------------------------------------------
// tb_led_pattern_top : table/scoreboard bench for the LED sequencer
// Rev 1.0
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module tb_led_pattern_top;
  import led_pattern_pkg::*;

  localparam int CPS = 400;
  localparam int L   = CPS;
  localparam int L3  = 3 * CPS;

  typedef enum int {ACT_NONE, ACT_B0, ACT_B1, ACT_BOTH} act_e;
  typedef struct {
    act_e       act;
    int         cyc;
    logic [3:0] exp;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       btn0;
  logic       btn1;
  logic [3:0] leds;

  int         checks = 0;
  int         errors = 0;
  logic [3:0] sb_q[$];
  vec_t       tbl[$];

  always #4 clk = ~clk;

  led_pattern_top #(
    .CYCLES_PER_SEC  (CPS),
    .SLOW_FACTOR     (3),
    .DEBOUNCE_CYCLES (8)
  ) dut (
    .clk  (clk),
    .rst  (rst),
    .btn0 (btn0),
    .btn1 (btn1),
    .leds (leds)
  );

  function automatic void add(input act_e a, input int c, input logic [3:0] e);
    vec_t v;
    v.act = a;
    v.cyc = c;
    v.exp = e;
    tbl.push_back(v);
  endfunction

  task automatic check_pop(input string name);
    logic [3:0] e;
    checks++;
    if (sb_q.size() == 0) begin
      errors++;
      $display("FAIL %s: scoreboard empty, leds=%b", name, leds);
      return;
    end
    e = sb_q.pop_front();
    if (leds !== e) begin
      errors++;
      $display("FAIL %s: leds=%b expected %b", name, leds, e);
    end
  endtask

  // A press is held 12 cycles (96 ns); the sample lands v.cyc cycles after it starts.
  task automatic apply(input vec_t v, input string name);
    int used;
    used = 0;
    btn0 = (v.act == ACT_B0) || (v.act == ACT_BOTH);
    btn1 = (v.act == ACT_B1) || (v.act == ACT_BOTH);
    sb_q.push_back(v.exp);
    if (v.act != ACT_NONE) begin
      repeat (12) @(posedge clk);
      #1;
      btn0 = 1'b0;
      btn1 = 1'b0;
      used = 12;
    end
    repeat (v.cyc - used) @(posedge clk);
    #1;
    check_pop(name);
  endtask

  task automatic run(input int lo, input int hi);
    for (int i = lo; i < hi; i++) apply(tbl[i], $sformatf("vec%0d", i));
  endtask

  task automatic onehot_monitor();
    forever begin
      @(negedge clk);
      checks++;
      if (!$onehot(leds)) begin
        errors++;
        $display("FAIL onehot: leds=%b required one-hot", leds);
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t v;
    int   s1, s2, s3, s4, s5, s6;

    rst  = 1'b1;
    btn0 = 1'b0;
    btn1 = 1'b0;

    // Mode A, 1 s from reset
    add(ACT_NONE, L + 50, 4'b0010);
    add(ACT_NONE, L, 4'b0100);
    add(ACT_NONE, L, 4'b1000);
    add(ACT_NONE, L, 4'b0100);
    add(ACT_NONE, L, 4'b0010);
    add(ACT_NONE, L, 4'b0001);
    add(ACT_NONE, L, 4'b0010);
    s1 = tbl.size();
    // btn0 -> Mode B, 1 s
    add(ACT_B0, 25, 4'b0001);
    add(ACT_NONE, L, 4'b0010);
    add(ACT_NONE, L, 4'b0100);
    add(ACT_NONE, L, 4'b1000);
    add(ACT_NONE, L, 4'b0001);
    add(ACT_NONE, L, 4'b0010);
    s2 = tbl.size();
    // btn1 -> 3 s, position kept
    add(ACT_B1, 25, 4'b0010);
    add(ACT_NONE, L, 4'b0010);
    add(ACT_NONE, L, 4'b0010);
    add(ACT_NONE, L, 4'b0100);
    add(ACT_NONE, L3, 4'b1000);
    s3 = tbl.size();
    // btn0 -> Mode A, still 3 s
    add(ACT_B0, 25, 4'b0001);
    add(ACT_NONE, L3, 4'b0010);
    add(ACT_NONE, L3, 4'b0100);
    add(ACT_NONE, L3, 4'b1000);
    s4 = tbl.size();
    // after async reset: Mode A, 1 s
    add(ACT_NONE, L + 50, 4'b0010);
    add(ACT_NONE, L, 4'b0100);
    add(ACT_NONE, L, 4'b1000);
    add(ACT_NONE, L, 4'b0100);
    s5 = tbl.size();
    // both buttons together -> Mode B, 3 s, LED reset
    add(ACT_BOTH, 25, 4'b0001);
    add(ACT_NONE, L, 4'b0001);
    add(ACT_NONE, 2 * L, 4'b0010);
    add(ACT_NONE, L3, 4'b0100);
    add(ACT_NONE, L3, 4'b1000);
    add(ACT_NONE, L3, 4'b0001);
    s6 = tbl.size();

    repeat (3) @(posedge clk);
    #1;
    sb_q.push_back(LED_INIT);
    check_pop("reset_state");
    fork
      onehot_monitor();
    join_none
    rst = 1'b0;

    run(0, s1);
    run(s1, s2);
    run(s2, s3);
    run(s3, s4);

    // Long hold of btn0: exactly one toggle (A -> B), release does nothing
    btn0 = 1'b1;
    sb_q.push_back(4'b0001);
    repeat (25) @(posedge clk);
    #1;
    check_pop("hold_press");
    sb_q.push_back(4'b0010);
    repeat (L3) @(posedge clk);
    #1;
    check_pop("hold_step");
    repeat (5 * L - 25 - L3) @(posedge clk);
    #1;
    btn0 = 1'b0;
    sb_q.push_back(4'b0100);
    repeat (L + 25) @(posedge clk);
    #1;
    check_pop("hold_release");

    // 5-cycle glitch must be rejected
    btn0 = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    btn0 = 1'b0;
    sb_q.push_back(4'b1000);
    repeat (L3 - 5) @(posedge clk);
    #1;
    check_pop("glitch_ignored");

    // Asynchronous reset mid-pattern
    rst = 1'b1;
    #2;
    sb_q.push_back(LED_INIT);
    check_pop("async_reset");
    @(posedge clk);
    #1;
    rst = 1'b0;
    run(s4, s5);
    run(s5, s6);

    // btn1 pulse lands on the step-tick edge: press wins, no step
    repeat (L3 - 25) @(posedge clk);
    #1;
    v.act = ACT_B1;
    v.cyc = 25;
    v.exp = 4'b0001;
    apply(v, "press_on_tick");
    v.act = ACT_NONE;
    v.cyc = L;
    v.exp = 4'b0010;
    apply(v, "after_press_on_tick");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
